// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: IDLE -> FETCH -> ISSUE -> RESOLVE, every output registered.
// Define FETCH_TIMEOUT_EN to pulse fetch_err after TIMEOUT FETCH cycles without imem_valid.
module fetch_sequencer #(
    parameter int PC_W    = 8,
    parameter int TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic [7:0]      imem_rdata,
    input  logic            imem_valid,
    output logic [2:0]      opcode,
    output logic            opcode_valid,
    output logic [4:0]      operand,
    input  logic            jmp_op,
    output logic [PC_W-1:0] pc,
    output logic            fetch_err
);
    localparam logic [2:0] NOP = 3'b111;

    typedef enum logic [1:0] {IDLE, FETCH, ISSUE, RESOLVE} state_t;
    state_t state;

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] tmo_cnt;
`else
    wire unused_timeout = (TIMEOUT > 0);
    assign fetch_err = 1'b0;
`endif

    // Next pc is computed from the captured operand; jmp_op only matters in RESOLVE.
    logic [PC_W-1:0] next_pc;
    always_comb begin
        next_pc = pc + PC_W'(1);
        if (jmp_op) next_pc = PC_W'(operand);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            pc           <= '0;
            imem_req     <= 1'b0;
            imem_addr    <= '0;
            opcode       <= NOP;
            opcode_valid <= 1'b0;
            operand      <= '0;
`ifdef FETCH_TIMEOUT_EN
            fetch_err    <= 1'b0;
            tmo_cnt      <= '0;
`endif
        end else begin
`ifdef FETCH_TIMEOUT_EN
            fetch_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (run) begin
                        state     <= FETCH;
                        imem_req  <= 1'b1;
                        imem_addr <= pc;
                    end
                end
                FETCH: begin
                    if (imem_valid) begin
                        state        <= ISSUE;
                        imem_req     <= 1'b0;
                        opcode       <= imem_rdata[7:5];
                        operand      <= imem_rdata[4:0];
                        opcode_valid <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
                        tmo_cnt      <= '0;
                    end else if (tmo_cnt == CNT_W'(TIMEOUT - 1)) begin
                        // Report and retry: the request stays up on the same address.
                        fetch_err <= 1'b1;
                        tmo_cnt   <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
`endif
                    end
                end
                ISSUE: begin
                    state        <= RESOLVE;
                    opcode       <= NOP;
                    opcode_valid <= 1'b0;
                end
                RESOLVE: begin
                    pc <= next_pc;
                    if (run) begin
                        state     <= FETCH;
                        imem_req  <= 1'b1;
                        imem_addr <= next_pc;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: issue, jump, wrap, stalled fetch, reset in FETCH, timeout.
module tb_fetch_sequencer;
    localparam int PC_W    = 8;
    localparam int TIMEOUT = 15;

    logic            clk = 1'b0;
    logic            rst, run, imem_valid, jmp_op;
    logic [7:0]      imem_rdata;
    logic            imem_req, opcode_valid, fetch_err;
    logic [PC_W-1:0] imem_addr, pc;
    logic [2:0]      opcode;
    logic [4:0]      operand;

    int n_cmp = 0;
    int n_err = 0;
    logic [PC_W-1:0] exp_pc;

    fetch_sequencer #(.PC_W(PC_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .run(run),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_valid(imem_valid),
        .opcode(opcode), .opcode_valid(opcode_valid), .operand(operand),
        .jmp_op(jmp_op), .pc(pc), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at the first FETCH cycle; leaves the bench one cycle after RESOLVE.
    task automatic do_instr(input logic [7:0] w, input int dly, input bit jmp, input bit run_after);
        for (int i = 0; i < dly; i++) begin
            chk("stall_req", imem_req, 1);
            chk("stall_addr", imem_addr, exp_pc);
            chk("stall_no_issue", opcode_valid, 0);
            step;
        end
        imem_rdata = w;
        imem_valid = 1'b1;
        chk("fetch_req", imem_req, 1);
        chk("fetch_addr", imem_addr, exp_pc);
        step;
        imem_valid = 1'b0;
        chk("issue_valid", opcode_valid, 1);
        chk("issue_opcode", opcode, {29'd0, w[7:5]});
        chk("issue_operand", operand, {27'd0, w[4:0]});
        chk("issue_req", imem_req, 0);
        jmp_op = ~jmp;       // must be ignored outside RESOLVE
        run    = run_after;
        step;
        chk("resolve_valid", opcode_valid, 0);
        chk("resolve_opcode", opcode, 3'b111);
        jmp_op     = jmp;
        imem_valid = 1'b1;   // stray valid outside FETCH
        imem_rdata = 8'hE7;
        step;
        jmp_op     = 1'b0;
        imem_valid = 1'b0;
        exp_pc = jmp ? {3'b000, w[4:0]} : exp_pc + 8'd1;
        chk("next_pc", pc, exp_pc);
        chk("next_req", imem_req, {31'd0, run_after});
        if (run_after) chk("next_addr", imem_addr, exp_pc);
        chk("next_no_issue", opcode_valid, 0);
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; imem_valid = 1'b0; jmp_op = 1'b0; imem_rdata = 8'h00;
        step; step;
        rst = 1'b0;
        chk("rst_pc", pc, 0);
        chk("rst_req", imem_req, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_opcode", opcode, 3'b111);
        chk("rst_ovalid", opcode_valid, 0);
        chk("rst_operand", operand, 0);
        chk("rst_err", fetch_err, 0);

        run = 1'b1;
        step;
        exp_pc = 8'd0;
        do_instr(8'h05, 0, 1'b0, 1'b1);   // pc 0 -> 1
        do_instr(8'h42, 0, 1'b0, 1'b1);   // pc 1 -> 2
        do_instr(8'h60, 0, 1'b0, 1'b1);   // pc 2 -> 3
        do_instr(8'h8A, 0, 1'b1, 1'b1);   // jump to 10
        chk("jump_pc", pc, 10);
        do_instr(8'h41, 4, 1'b0, 1'b1);   // stalled fetch, pc 10 -> 11
        do_instr(8'h9F, 0, 1'b1, 1'b1);   // jump to 31
        for (int k = 0; k < 224; k++) do_instr(8'h20, 0, 1'b0, 1'b1);
        chk("pre_wrap_pc", pc, 8'hFF);
        do_instr(8'h22, 0, 1'b0, 1'b0);   // 0xFF wraps to 0, then idle
        chk("wrap_pc", pc, 8'h00);
        step;
        chk("idle_req", imem_req, 0);
        chk("idle_ovalid", opcode_valid, 0);

        // Reset during FETCH with a late imem_valid
        run = 1'b1;
        step;
        chk("rf_req", imem_req, 1);
        rst = 1'b1; run = 1'b0;
        step;
        rst = 1'b0;
        imem_valid = 1'b1; imem_rdata = 8'h8A;
        chk("rf_req_drop", imem_req, 0);
        chk("rf_ovalid", opcode_valid, 0);
        chk("rf_opcode", opcode, 3'b111);
        chk("rf_operand", operand, 0);
        chk("rf_pc", pc, 0);
        chk("rf_addr", imem_addr, 0);
        step;
        chk("rf_late_ovalid", opcode_valid, 0);
        chk("rf_late_req", imem_req, 0);
        chk("rf_late_pc", pc, 0);
        imem_valid = 1'b0;

        // Fetch with no response: timeout pulse only when the feature is built in
        run = 1'b1;
        step;
        chk("to_req0", imem_req, 1);
        for (int i = 1; i <= 20; i++) begin
            step;
`ifdef FETCH_TIMEOUT_EN
            chk("to_err", fetch_err, {31'd0, i == TIMEOUT});
`else
            chk("to_err", fetch_err, 0);
`endif
            chk("to_req", imem_req, 1);
            chk("to_addr", imem_addr, 0);
            chk("to_no_issue", opcode_valid, 0);
        end
        rst = 1'b1;
        step;
        chk("final_req", imem_req, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 The block SHALL have parameter PC_W, default 8, meaning program-counter and instruction-address width (minimum 5).
REQ-002 The block SHALL have parameter TIMEOUT, default 15, meaning fetch-timeout limit in cycles (used only with FETCH_TIMEOUT_EN).
REQ-003 The block SHALL have port clk  input  1  clock; all logic on the rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port run  input  1  level enable; the sequencer leaves IDLE only while high.
REQ-006 The block SHALL have port imem_req  output  1  instruction-read request, held until accepted.
REQ-007 The block SHALL have port imem_addr  output  PC_W  instruction address; equals pc while imem_req is high.
REQ-008 The block SHALL have port imem_rdata  input  8  instruction word: [7:5] opcode, [4:0] operand.
REQ-009 The block SHALL have port imem_valid  input  1  imem_rdata valid; completes the pending request.
REQ-010 The block SHALL have port opcode  output  3  opcode driven to the control unit.
REQ-011 The block SHALL have port opcode_valid  output  1  one-cycle pulse marking the issue cycle.
REQ-012 The block SHALL have port operand  output  5  operand of the issued instruction (jump target for 3'b100).
REQ-013 The block SHALL have port jmp_op  input  1  registered jump decision from the control unit, valid one cycle after issue.
REQ-014 The block SHALL have port pc  output  PC_W  current program counter.
REQ-015 The block SHALL have port fetch_err  output  1  one-cycle fetch-timeout pulse.

Function
REQ-016 The FSM SHALL have states IDLE, FETCH, ISSUE, RESOLVE; all outputs registered.
REQ-017 IDLE SHALL move to FETCH on the cycle after run is sampled high; imem_req is high throughout FETCH.
REQ-018 In FETCH, imem_valid SHALL be sampled every cycle, including the first; on imem_valid=1 the instruction is captured and the FSM moves to ISSUE.
REQ-019 imem_addr SHALL stay stable while imem_req is high; imem_valid outside FETCH SHALL be ignored.
REQ-020 In ISSUE (exactly one cycle), opcode and operand SHALL carry the captured fields and opcode_valid SHALL be 1.
REQ-021 Outside ISSUE, opcode SHALL be 3'b111 (no-op) and opcode_valid SHALL be 0.
REQ-022 RESOLVE SHALL last one cycle and sample jmp_op: if 1, pc <= operand zero-extended to PC_W; else pc <= pc+1 modulo 2^PC_W (wrap from all-ones to 0).
REQ-023 jmp_op outside RESOLVE SHALL be ignored.
REQ-024 From RESOLVE the FSM SHALL go to FETCH if run=1, else to IDLE.
REQ-025 Issue throughput SHALL be one instruction per 3 cycles minimum (FETCH with immediate imem_valid, ISSUE, RESOLVE).
REQ-026 Deasserting run SHALL NOT abort an instruction in FETCH, ISSUE or RESOLVE; it only stops the next fetch.

Reset
REQ-027 rst SHALL take priority over all other inputs in every state.
REQ-028 On rst: state=IDLE, pc=0, imem_req=0, imem_addr=0, opcode=3'b111, opcode_valid=0, operand=0, fetch_err=0, timeout counter=0.
REQ-029 rst during FETCH SHALL drop imem_req on the following cycle; a subsequent late imem_valid SHALL be ignored.

Configuration
REQ-030 With macro FETCH_TIMEOUT_EN defined, a counter SHALL count FETCH cycles without imem_valid; on reaching TIMEOUT it SHALL pulse fetch_err for one cycle, clear the counter, and keep requesting the same address.
REQ-031 Without FETCH_TIMEOUT_EN, FETCH SHALL wait indefinitely and fetch_err SHALL be tied to 0; the port list is unchanged.

Verification
REQ-032 Reset then run=1, memory returns 8'h05 at addr 0 immediately -> issue opcode=000, operand=5'h05, opcode_valid one cycle, jmp_op=0, pc becomes 1.
REQ-033 Instruction 8'h8A (jump, target 10) at pc=3 and jmp_op=1 in RESOLVE -> pc=10, next imem_addr=10.
REQ-034 PC_W=8, pc=8'hFF, non-jump instruction -> pc wraps to 8'h00.
REQ-035 imem_valid delayed 4 cycles -> imem_req high and imem_addr stable for 5 cycles, one issue only.
REQ-036 rst pulsed during FETCH with imem_valid arriving the next cycle -> no issue, all outputs at reset values, pc=0.
REQ-037 With FETCH_TIMEOUT_EN and TIMEOUT=15, no imem_valid for 15 FETCH cycles -> fetch_err pulses once, imem_req stays high, same imem_addr.
